// File: rtl/counter8_ctrl.sv
// Command-driven control stage for the 8-bit loadable counter: accepts STOP/LOAD/RUN/SETOE
// over valid/ready and generates en (prescaled), load, load_val and oe.
module counter8_ctrl #(
   parameter int   DIV_W  = 8,
   parameter logic OE_RST = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [7:0] cmd_data,
   output logic       en,
   output logic       load,
   output logic [7:0] load_val,
   output logic       oe,
   output logic       running
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_LOAD = 2'd2;

   localparam logic [1:0] OP_STOP  = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_RUN   = 2'b10;
   localparam logic [1:0] OP_SETOE = 2'b11;

   logic [1:0]       r_state;
   logic             r_ret_run;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_pc;
   logic             r_load;
   logic [7:0]       r_load_val;
   logic             r_oe;
   logic             r_ready;

   logic [DIV_W-1:0] w_data_div;
   logic             w_accept;
   logic             w_pc_wrap;

   // Operand is zero-extended or truncated to the prescaler width.
   generate
      if (DIV_W > 8) begin : g_data_ext
         assign w_data_div = {{(DIV_W-8){1'b0}}, cmd_data};
      end else if (DIV_W == 8) begin : g_data_eq
         assign w_data_div = cmd_data;
      end else begin : g_data_trunc
         assign w_data_div = cmd_data[DIV_W-1:0];
      end
   endgenerate

   assign cmd_ready = r_ready & ~rst & (r_state != ST_LOAD);
   assign w_accept  = cmd_valid & cmd_ready;
   assign w_pc_wrap = (r_pc == r_div);

   assign en       = (r_state == ST_RUN) & w_pc_wrap;
   assign load     = r_load;
   assign load_val = r_load_val;
   assign oe       = r_oe;
   assign running  = (r_state == ST_RUN) | ((r_state == ST_LOAD) & r_ret_run);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_ret_run  <= 1'b0;
         r_div      <= '0;
         r_pc       <= '0;
         r_load     <= 1'b0;
         r_load_val <= 8'h00;
         r_oe       <= OE_RST;
         r_ready    <= 1'b0;
      end else begin
         r_ready <= 1'b1;
         r_load  <= 1'b0;

         case (r_state)
            ST_RUN:  r_pc <= w_pc_wrap ? '0 : r_pc + DIV_W'(1);
            ST_LOAD: begin
               r_state <= r_ret_run ? ST_RUN : ST_IDLE;
               r_pc    <= '0;
            end
            ST_IDLE: r_pc <= '0;
            default: begin
               r_state <= ST_IDLE;
               r_pc    <= '0;
            end
         endcase

         // Never taken in LOAD since cmd_ready is low there.
         if (w_accept) begin
            case (cmd_op)
               OP_STOP: begin
                  r_state <= ST_IDLE;
                  r_pc    <= '0;
               end
               OP_LOAD: begin
                  r_state    <= ST_LOAD;
                  r_ret_run  <= (r_state == ST_RUN);
                  r_load     <= 1'b1;
                  r_load_val <= cmd_data;
                  r_pc       <= '0;
               end
               OP_RUN: begin
                  r_state <= ST_RUN;
                  r_div   <= w_data_div;
                  r_pc    <= '0;
               end
               OP_SETOE: r_oe <= cmd_data[0];
               default:  r_oe <= r_oe;
            endcase
         end
      end
   end

endmodule
